// File: rtl/wb_regfile.sv
// Write-back register file: 32 x 32-bit array with a hardwired-zero entry 0,
// two registered read ports with same-edge write bypass, and a committed-write counter.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] wb_sel,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] rd_sel_a,
  input  logic [ADDR_W-1:0] rd_sel_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [CNT_W-1:0]  wb_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic [CNT_W-1:0]  wb_count_q, wb_count_d;
  logic              wb_commit;

  // Next-state: the read ports sample the post-write array, which gives the bypass for free.
  always_comb begin
    regs_d      = regs_q;
    wb_commit   = wb_en && (wb_sel != '0);
    if (wb_commit) begin
      regs_d[wb_sel] = wb_data;
    end
    regs_d[0]   = '0;
    rd_data_a_d = (rd_sel_a == '0) ? '0 : regs_d[rd_sel_a];
    rd_data_b_d = (rd_sel_b == '0) ? '0 : regs_d[rd_sel_b];
    wb_count_d  = wb_count_q + CNT_W'(wb_commit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      wb_count_q  <= '0;
    end else begin
      regs_q      <= regs_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      wb_count_q  <= wb_count_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign wb_count  = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a reference array predicts each edge's outputs,
// which are queued at drive time and popped after the edge.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] wb_data;
  logic [4:0]  wb_sel;
  logic        wb_en;
  logic [4:0]  rd_sel_a;
  logic [4:0]  rd_sel_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [15:0] wb_count;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .wb_data(wb_data), .wb_sel(wb_sel), .wb_en(wb_en),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model[32];
  logic [15:0] model_cnt;
  int          checks;
  int          failures;

  function automatic logic [31:0] predict(input logic en, input logic [4:0] sel,
                                          input logic [31:0] data, input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (en && sel != 5'd0 && sel == rs) return data;
    return model[rs];
  endfunction

  // Present one cycle of stimulus, enqueue the expected outputs, then step past the edge.
  task automatic drive(input logic en, input logic [4:0] sel, input logic [31:0] data,
                       input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    @(negedge clk);
    wb_en = en; wb_sel = sel; wb_data = data; rd_sel_a = ra; rd_sel_b = rb;
    e.a = predict(en, sel, data, ra);
    e.b = predict(en, sel, data, rb);
    if (en && sel != 5'd0) begin
      model[sel] = data;
      model_cnt  = model_cnt + 16'd1;
    end
    e.cnt = model_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    wb_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wb_en = 1'b0;
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model_cnt = 16'd0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0; wb_en = 1'b0; wb_sel = '0; wb_data = '0; rd_sel_a = '0; rd_sel_b = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model_cnt = 16'd0;
    #2;
    checks++;
    if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0 || wb_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: got a=%h b=%h cnt=%h required all zero", rd_data_a, rd_data_b, wb_count);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      e = sb_q.pop_front();
      checks++;
      if (rd_data_a !== e.a || rd_data_b !== e.b || wb_count !== e.cnt) begin
        failures++;
        $display("FAIL reset_read[%0d]: got a=%h b=%h cnt=%h required a=%h b=%h cnt=%h",
                 i, rd_data_a, rd_data_b, wb_count, e.a, e.b, e.cnt);
      end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    e = sb_q.pop_front();
    checks++;
    if (wb_count !== e.cnt || wb_count !== 16'd1) begin
      failures++;
      $display("FAIL basic_count: got %h required %h", wb_count, e.cnt);
    end
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    e = sb_q.pop_front();
    checks++;
    if (rd_data_a !== e.a || rd_data_a !== 32'hDEADBEEF || rd_data_b !== e.b) begin
      failures++;
      $display("FAIL basic_read: got a=%h b=%h required a=%h b=%h", rd_data_a, rd_data_b, e.a, e.b);
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    drive(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
    void'(sb_q.pop_front());
    drive(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7);
    e = sb_q.pop_front();
    checks++;
    if (rd_data_a !== e.a || rd_data_b !== e.b || rd_data_a !== 32'h22222222) begin
      failures++;
      $display("FAIL bypass_both: got a=%h b=%h required a=%h b=%h", rd_data_a, rd_data_b, e.a, e.b);
    end
    drive(1'b1, 5'd9, 32'hA5A5_0009, 5'd9, 5'd7);
    e = sb_q.pop_front();
    checks++;
    if (rd_data_a !== e.a || rd_data_b !== e.b || wb_count !== e.cnt) begin
      failures++;
      $display("FAIL bypass_split: got a=%h b=%h cnt=%h required a=%h b=%h cnt=%h",
               rd_data_a, rd_data_b, wb_count, e.a, e.b, e.cnt);
    end
  endtask

  task automatic test_r0();
    exp_t e;
    logic [15:0] cnt_before;
    cnt_before = model_cnt;
    for (int k = 0; k < 2; k++) begin
      drive(k == 0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7);
      e = sb_q.pop_front();
      checks++;
      if (rd_data_a !== 32'h0 || rd_data_b !== e.b || wb_count !== cnt_before) begin
        failures++;
        $display("FAIL r0_protect[%0d]: got a=%h b=%h cnt=%h required a=0 b=%h cnt=%h",
                 k, rd_data_a, rd_data_b, wb_count, e.b, cnt_before);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
            5'($urandom), 5'($urandom));
      e = sb_q.pop_front();
      checks++;
      if (rd_data_a !== e.a || rd_data_b !== e.b || wb_count !== e.cnt) begin
        failures++;
        if (errs < 5)
          $display("FAIL b2b[%0d]: got a=%h b=%h cnt=%h required a=%h b=%h cnt=%h",
                   i, rd_data_a, rd_data_b, wb_count, e.a, e.b, e.cnt);
        errs++;
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    int   errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, 5'd1, 32'h1000_0000 + 32'(i), 5'd2, 5'd0);
      e = sb_q.pop_front();
      checks++;
      if (wb_count !== e.cnt) begin
        failures++;
        if (errs < 5) $display("FAIL wrap_count[%0d]: got %h required %h", i, wb_count, e.cnt);
        errs++;
      end
    end
    checks++;
    if (wb_count !== 16'h0) begin
      failures++;
      $display("FAIL wrap_zero: got %h required 0000", wb_count);
    end
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd1);
    e = sb_q.pop_front();
    checks++;
    if (rd_data_a !== 32'h1000_FFFF || rd_data_b !== e.b) begin
      failures++;
      $display("FAIL wrap_last: got a=%h b=%h required %h", rd_data_a, rd_data_b, 32'h1000_FFFF);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1));
      void'(sb_q.pop_front());
    end
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd17);
    e = sb_q.pop_front();
    checks++;
    if (rd_data_a !== e.a || rd_data_b !== e.b || rd_data_a !== 32'd31) begin
      failures++;
      $display("FAIL fill_check: got a=%h b=%h required a=%h b=%h", rd_data_a, rd_data_b, e.a, e.b);
    end
    // Pull reset mid-cycle with a write pending; it must never land.
    #2;
    wb_en = 1'b1; wb_sel = 5'd3; wb_data = 32'hCAFE_F00D;
    rst = 1'b0;
    #1;
    checks++;
    if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0 || wb_count !== 16'h0) begin
      failures++;
      $display("FAIL async_clear: got a=%h b=%h cnt=%h required all zero", rd_data_a, rd_data_b, wb_count);
    end
    @(posedge clk);
    @(negedge clk);
    wb_en = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model_cnt = 16'd0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      e = sb_q.pop_front();
      checks++;
      if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0 || wb_count !== e.cnt) begin
        failures++;
        $display("FAIL post_reset_read[%0d]: got a=%h b=%h cnt=%h required zero", i, rd_data_a, rd_data_b, wb_count);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_bypass();
    test_r0();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back register file for the 4-stage 32-bit pipelined datapath. It is the receiving end of the stage-3 write-back interface: it consumes the stage-3 result, destination select and write enable, and commits the result into a 32-entry x 32-bit register array. It also serves the two stage-1 operand read ports with registered outputs and same-edge write-to-read bypass. A wrapping count of committed writes is kept for debug and verification.

## Interface
- DATA_W, 32, register and data width
- ADDR_W, 5, register select width (2^ADDR_W entries)
- CNT_W, 16, width of the committed-write counter
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low; clears all state immediately when low
- wb_data  input  DATA_W  stage-3 result to commit
- wb_sel  input  ADDR_W  stage-3 destination register select
- wb_en  input  1  stage-3 write enable; commit when high at rising edge
- rd_sel_a  input  ADDR_W  operand A register select (stage 1)
- rd_sel_b  input  ADDR_W  operand B register select (stage 1)
- rd_data_a  output  DATA_W  registered operand A value
- rd_data_b  output  DATA_W  registered operand B value
- wb_count  output  CNT_W  number of committed writes, modulo 2^CNT_W

## Operation
- Array: 2^ADDR_W entries of DATA_W bits. Entry 0 is hardwired zero: never written, always reads 0.
- Write: at a rising edge with rst high, wb_en=1 and wb_sel!=0, entry[wb_sel] <= wb_data. wb_en=0 or wb_sel=0: array unchanged.
- Read: at every rising edge with rst high, rd_data_a <= value of entry[rd_sel_a], rd_data_b <= value of entry[rd_sel_b], evaluated with bypass:
  - If wb_en=1, wb_sel!=0 and wb_sel==rd_sel_x at the same edge, rd_data_x <= wb_data (new value, not old array contents).
  - If rd_sel_x==0, rd_data_x <= 0 regardless of write-back.
  - Both ports are independent; both may select the same entry, and both may bypass in the same cycle.
- Counter: wb_count increments by 1 on each committed write (wb_en=1, wb_sel!=0). Writes to entry 0 are not counted. Wraps from 2^CNT_W-1 to 0 with no flag.
- Reset (rst low, any time, no clock needed): all array entries, rd_data_a, rd_data_b and wb_count go to 0 immediately and hold while rst is low. A write presented in the cycle rst falls is discarded. The first edge after rst rises behaves normally.
- No X propagation: unused select values do not exist (full 2^ADDR_W decode).

## Timing
- Write latency: data is in the array at the edge where wb_en is sampled. A read select presented at that same edge returns the new value through the bypass. Any later edge returns it from the array.
- Read latency: 1 cycle. rd_data_x reflects rd_sel_x sampled at the previous rising edge.
- wb_count updates at the same edge as the committed write. Visible on the output right after that edge.
- Reset values: rd_data_a=0, rd_data_b=0, wb_count=0, all entries 0.
- No handshake or backpressure. Every edge with wb_en=1 commits. The array accepts one write per cycle, back-to-back.

## Test plan
- Reset then read: rst low, release, then read entries 0..31 on both ports -> all return 0x00000000, wb_count=0.
- Basic write/read: write 0xDEADBEEF to R5, next cycle set rd_sel_a=5 -> rd_data_a=0xDEADBEEF one cycle later, wb_count=1.
- Same-edge bypass: R7 holds 0x11111111. At one edge drive wb_en=1, wb_sel=7, wb_data=0x22222222 and rd_sel_a=rd_sel_b=7 -> both outputs read 0x22222222 after that edge.
- R0 protection: wb_en=1, wb_sel=0, wb_data=0xFFFFFFFF, with rd_sel_a=0 at the same and the next edge -> rd_data_a=0 both times, wb_count unchanged.
- Counter wrap: perform 65536 committed writes to R1 -> wb_count returns to 0, and R1 holds the last value written.
- Async reset mid-stream: fill R1..R31 with their index, then pull rst low between edges -> all outputs 0 before the next edge. After release, every read returns 0.
